// File: rtl/ofdm_buf_pkg.sv
// Shared constants for the OFDM Rx output buffer: register offsets,
// STATUS bit positions, FSM state encoding and the STATUS word packer.
package ofdm_buf_pkg;

    localparam logic [4:0] OFS_STATUS = 5'h1C;

    localparam int STAT_VALID   = 0;
    localparam int STAT_SHORT   = 1;
    localparam int STAT_NOTLAST = 2;
    localparam int STAT_CNT_LSB = 8;
    localparam int CNT_W        = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    function automatic logic [31:0] pack_status(
        input logic             valid,
        input logic             short_f,
        input logic             notlast,
        input logic [CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w                          = '0;
        w[STAT_VALID]              = valid;
        w[STAT_SHORT]              = short_f;
        w[STAT_NOTLAST]            = notlast;
        w[STAT_CNT_LSB +: CNT_W]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/ofdm_axil_slave_if.sv
// AXI-Lite slave handshake engine: one outstanding write and one outstanding
// read; read data is captured at the address handshake and held until rready.
module ofdm_axil_slave_if #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [AW-1:0]   s_awaddr,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [DW-1:0]   s_wdata,
    input  logic [DW/8-1:0] s_wstrb,
    input  logic            s_wvalid,
    output logic            s_wready,
    output logic [1:0]      s_bresp,
    output logic            s_bvalid,
    input  logic            s_bready,
    input  logic [AW-1:0]   s_araddr,
    input  logic            s_arvalid,
    output logic            s_arready,
    output logic [DW-1:0]   s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [DW/8-1:0] wr_strb,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data
);

    logic          awready_q, awready_d;
    logic          bvalid_q, bvalid_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // Handshake next-state: single-cycle ready pulses, valid held until taken
    always_comb begin
        wr_en     = awready_q & s_awvalid & s_wvalid;
        rd_en     = arready_q & s_arvalid;
        awready_d = s_awvalid & s_wvalid & ~bvalid_q & ~awready_q;
        arready_d = s_arvalid & ~rvalid_q & ~arready_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (wr_en) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s_bready) begin
            bvalid_d = 1'b0;
        end
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
        end else if (rvalid_q && s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Handshake registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = awready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = 2'b00;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = 2'b00;
    assign wr_addr   = s_awaddr;
    assign wr_data   = s_wdata;
    assign wr_strb   = s_wstrb;
    assign rd_addr   = s_araddr;

endmodule

// File: rtl/ofdm_rx_output_buffer_lite.sv
// OFDM Rx output buffer: captures one AXI-Stream frame, holds it for AXI-Lite
// readout until released. Optional level irq when OFDM_RXBUF_IRQ_EN is defined.
module ofdm_rx_output_buffer_lite
    import ofdm_buf_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH   = 32,
    parameter int C_S00_AXI_ADDR_WIDTH   = 5,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_NUM_WORDS            = 7
) (
`ifdef OFDM_RXBUF_IRQ_EN
    output logic                                irq,
`endif
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    input  logic                                s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                                s00_axis_tlast,
    output logic                                s00_axis_tready
);

    localparam int AW = C_S00_AXI_ADDR_WIDTH;
    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int TW = C_S00_AXIS_TDATA_WIDTH;
    localparam int IW = AW - 2;
    localparam logic [IW-1:0] STATUS_IDX = IW'(OFS_STATUS >> 2);

    logic            wr_en, rd_en;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic [DW-1:0]   wr_data, rd_data;
    logic [DW/8-1:0] wr_strb;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]   mem_q [C_NUM_WORDS];
    logic [TW-1:0]   mem_d [C_NUM_WORDS];
    logic            short_q, short_d;
    logic            notlast_q, notlast_d;
    logic            frame_valid;
    logic            beat;
    logic            last_word;
    logic            release_req;
    logic [IW-1:0]   rd_idx;
    logic            unused_ok;

    ofdm_axil_slave_if #(
        .AW (AW),
        .DW (DW)
    ) u_axil (
        .aclk      (aclk),
        .areset    (areset),
        .s_awaddr  (s00_axi_awaddr),
        .s_awvalid (s00_axi_awvalid),
        .s_awready (s00_axi_awready),
        .s_wdata   (s00_axi_wdata),
        .s_wstrb   (s00_axi_wstrb),
        .s_wvalid  (s00_axi_wvalid),
        .s_wready  (s00_axi_wready),
        .s_bresp   (s00_axi_bresp),
        .s_bvalid  (s00_axi_bvalid),
        .s_bready  (s00_axi_bready),
        .s_araddr  (s00_axi_araddr),
        .s_arvalid (s00_axi_arvalid),
        .s_arready (s00_axi_arready),
        .s_rdata   (s00_axi_rdata),
        .s_rresp   (s00_axi_rresp),
        .s_rvalid  (s00_axi_rvalid),
        .s_rready  (s00_axi_rready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, wr_addr[1:0],
                         rd_addr[1:0], wr_data[DW-1:1], wr_strb[DW/8-1:1]};

    assign beat        = s00_axis_tvalid && (state_q == ST_FILL);
    assign last_word   = (cnt_q == CNT_W'(C_NUM_WORDS - 1));
    assign release_req = wr_en && (wr_addr[AW-1:2] == STATUS_IDX)
                         && wr_strb[0] && wr_data[0];

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fill ends on tlast or on the last slot, release refills
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL: if (beat && (last_word || s00_axis_tlast)) state_d = ST_FULL;
            ST_FULL: if (release_req) state_d = ST_FILL;
        endcase
    end

    // FSM outputs; tready is forced low while reset is asserted
    always_comb begin
        s00_axis_tready = (state_q == ST_FILL) && !areset;
        frame_valid     = (state_q == ST_FULL);
    end

    // Buffer, count and frame flags next-state
    always_comb begin
        mem_d     = mem_q;
        cnt_d     = cnt_q;
        short_d   = short_q;
        notlast_d = notlast_q;
        if (beat) begin
            for (int i = 0; i < C_NUM_WORDS; i++) begin
                if (cnt_q == CNT_W'(i)) mem_d[i] = s00_axis_tdata;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (last_word) begin
                notlast_d = ~s00_axis_tlast;
            end else if (s00_axis_tlast) begin
                short_d = 1'b1;
            end
        end
        if (frame_valid && release_req) begin
            mem_d     = '{default: '0};
            cnt_d     = '0;
            short_d   = 1'b0;
            notlast_d = 1'b0;
        end
    end

    // Buffer and flag registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            mem_q     <= '{default: '0};
            cnt_q     <= '0;
            short_q   <= 1'b0;
            notlast_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            cnt_q     <= cnt_d;
            short_q   <= short_d;
            notlast_q <= notlast_d;
        end
    end

`ifdef OFDM_RXBUF_IRQ_EN
    logic irq_q, irq_d;

    // Level irq: set on entering FULL, cleared by release
    always_comb begin
        irq_d = irq_q;
        if (state_q == ST_FILL && state_d == ST_FULL) begin
            irq_d = 1'b1;
        end else if (release_req) begin
            irq_d = 1'b0;
        end
    end

    // irq register
    always_ff @(posedge aclk) begin
        if (areset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    // Read mux: STATUS, buffer words, zero elsewhere
    always_comb begin
        rd_idx  = rd_addr[AW-1:2];
        rd_data = '0;
        if (rd_en) begin
            if (rd_idx == STATUS_IDX) begin
                rd_data = DW'(pack_status(frame_valid, short_q, notlast_q, cnt_q));
            end else begin
                for (int i = 0; i < C_NUM_WORDS; i++) begin
                    if (rd_idx == IW'(i)) rd_data = DW'(mem_q[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_ofdm_rx_output_buffer_lite.sv
// Self-checking bench for ofdm_rx_output_buffer_lite: table-driven frames,
// hand-written corner sequences, then random frames against a frame-level model.
module tb_ofdm_rx_output_buffer_lite;

    localparam int N = 7;

    logic        aclk;
    logic        areset;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        tready;
`ifdef OFDM_RXBUF_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    ofdm_rx_output_buffer_lite dut (
`ifdef OFDM_RXBUF_IRQ_EN
        .irq             (irq),
`endif
        .aclk            (aclk),
        .areset          (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tdata  (tdata),
        .s00_axis_tlast  (tlast),
        .s00_axis_tready (tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Frame-level reference: what STATUS should say after a frame whose
    // tlast sits on beat tl (1-based, 0 = none), given enough beats.
    function automatic logic [31:0] model_status(input int tl);
        int n;
        logic s, nt;
        logic [3:0] n4;
        if (tl != 0 && tl < N) begin
            n = tl; s = 1'b1; nt = 1'b0;
        end else begin
            n = N; s = 1'b0; nt = (tl != N);
        end
        n4 = 4'(n);
        return {20'd0, n4, 5'd0, nt, s, 1'b1};
    endfunction

    // All bus tasks start and end just after a falling edge.
    task automatic axil_write(input logic [4:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int hold);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 16);
        check("awready", awready, 1);
        check("wready", wready, 1);
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid", bvalid, 1);
        check("bresp", bresp, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge aclk);
            check("bvalid_hold", bvalid, 1);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("bvalid_clr", bvalid, 0);
    endtask

    task automatic axil_read(input logic [4:0] a, input int hold, output logic [31:0] d);
        int n;
        araddr = a; arvalid = 1'b1; n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 16);
        check("arready", arready, 1);
        @(negedge aclk);
        if (hold == 0) arvalid = 1'b0;
        check("rvalid", rvalid, 1);
        check("rresp", rresp, 0);
        d = rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge aclk);
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, d);
            check("no_second_arready", arready, 0);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        check("rvalid_clr", rvalid, 0);
    endtask

    task automatic read_expect(input string nm, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axil_read(a, 0, d);
        check(nm, d, exp);
    endtask

    task automatic stream_beat(input logic [31:0] d, input logic l);
        tvalid = 1'b1; tdata = d; tlast = l;
        @(negedge aclk);
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    // Stream a frame, check STATUS and contents, release, check empty.
    task automatic run_frame(input int len, input int tl, input logic [31:0] exp_st,
                             input bit rnd, input int hold);
        logic [31:0] sent [16];
        logic [31:0] d;
        int acc;
        int n_exp;
        n_exp = int'(exp_st[11:8]);
        acc = 0;
        for (int i = 0; i < len; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge aclk);
            d = rnd ? $urandom : 32'h11 * (i + 1);
            sent[i] = d;
            tvalid = 1'b1; tdata = d; tlast = (i + 1 == tl);
            if (tready) begin
                acc++;
                @(negedge aclk);
                tvalid = 1'b0; tlast = 1'b0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge aclk);
                    check("extra_beat_held", tready, 0);
                end
                tvalid = 1'b0; tlast = 1'b0;
                break;
            end
        end
        check("tready_full", tready, 0);
        check("beats_accepted", acc, n_exp);
`ifdef OFDM_RXBUF_IRQ_EN
        check("irq_set", irq, 1);
`endif
        axil_read(5'h1C, hold, d);
        check("status_full", d, exp_st);
        for (int i = 0; i < N; i++) begin
            read_expect("buf_full", 5'(4 * i), (i < n_exp) ? sent[i] : 32'h0);
        end
        axil_write(5'h00, 32'hDEAD_BEEF, 4'hF, 0);
        read_expect("data_write_ignored", 5'h00, sent[0]);
        axil_write(5'h1C, 32'h1, 4'hE, 0);
        check("no_release_wstrb0", tready, 0);
        read_expect("status_wstrb0", 5'h1C, exp_st);
        axil_write(5'h1C, 32'h1, 4'h1, hold);
        check("tready_released", tready, 1);
`ifdef OFDM_RXBUF_IRQ_EN
        check("irq_clr", irq, 0);
`endif
        read_expect("status_released", 5'h1C, 32'h0);
        for (int i = 0; i < N; i++) begin
            read_expect("buf_cleared", 5'(4 * i), 32'h0);
        end
    endtask

    typedef struct {
        int          len;
        int          tl;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] d;
        int len, tl;

        vecs[0] = '{7, 7, 32'h0000_0701};
        vecs[1] = '{3, 3, 32'h0000_0303};
        vecs[2] = '{8, 0, 32'h0000_0705};
        vecs[3] = '{1, 1, 32'h0000_0103};
        vecs[4] = '{9, 8, 32'h0000_0705};
        vecs[5] = '{6, 6, 32'h0000_0603};

        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_tready", tready, 0);
`ifdef OFDM_RXBUF_IRQ_EN
        check("rst_irq", irq, 0);
`endif
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_tready", tready, 1);
        read_expect("post_rst_status", 5'h1C, 32'h0);
        read_expect("post_rst_buf0", 5'h00, 32'h0);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].len, vecs[v].tl, vecs[v].exp_status, 1'b0, (v == 0) ? 5 : 0);
        end

        stream_beat(32'hA1, 1'b0);
        stream_beat(32'hA2, 1'b0);
        axil_write(5'h1C, 32'h1, 4'h1, 0);
        check("release_in_fill_tready", tready, 1);
        read_expect("release_in_fill_status", 5'h1C, 32'h0000_0200);
        read_expect("release_in_fill_buf1", 5'h04, 32'hA2);

        stream_beat(32'hA3, 1'b0);
        stream_beat(32'hA4, 1'b0);
        araddr = 5'h1C; arvalid = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("pending_rvalid", rvalid, 1);
        awaddr = 5'h1C; wdata = 32'h1; wstrb = 4'h1;
        areset = 1'b1;
        @(negedge aclk);
        check("midrst_rvalid", rvalid, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_arready", arready, 0);
        check("midrst_bvalid", bvalid, 0);
        check("midrst_tready", tready, 0);
        arvalid = 1'b0;
        areset = 1'b0;
        @(negedge aclk);
        read_expect("midrst_status", 5'h1C, 32'h0);
        read_expect("midrst_buf0", 5'h00, 32'h0);
        read_expect("midrst_buf3", 5'h0C, 32'h0);
        run_frame(7, 7, 32'h0000_0701, 1'b0, 0);

        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(1, 10);
            tl  = $urandom_range(0, len);
            if (tl == 0 && len < N) len = N + $urandom_range(0, 2);
            run_frame(len, tl, model_status(tl), 1'b1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
